// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared constants and width helpers for the streaming Sobel engine.
//   - grad_w(PIX_W): signed width that holds Gx/Gy without overflow.
//   - mag_w(PIX_W) : unsigned width that holds |Gx|+|Gy| before saturation.
//   - LAT          : enabled cycles from window-completing accept to out_valid.
//   - K_SIDE/K_MID : Sobel kernel weights for the outer and middle taps.
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int unsigned LAT = 3;

  localparam int K_SIDE = 1;
  localparam int K_MID  = 2;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_stream_engine_if.sv
// -----------------------------------------------------------------------------
// sobel_stream_engine_if
//   Pixel-in / magnitude-out stream bundle for sobel_stream_engine.
//   Input side : in_valid, in_ready, in_sof, in_pix
//   Output side: out_valid, out_ready, out_pix, out_eof
//   modport slave  : the engine (consumes input stream, produces output stream)
//   modport master : the environment (frame source plus output writer)
// -----------------------------------------------------------------------------
interface sobel_stream_engine_if #(
  parameter int PIX_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pix;
  logic             out_eof;

  modport slave (
    input  in_valid, in_sof, in_pix, out_ready,
    output in_ready, out_valid, out_pix, out_eof
  );

  modport master (
    output in_valid, in_sof, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, out_eof
  );

endinterface

// File: rtl/sobel_line_buf.sv
// -----------------------------------------------------------------------------
// sobel_line_buf
//   One-line pixel store: one write port, one registered read port.
//   A read and a write to the same address in one cycle returns the old data.
//   Ports:
//     clk   in   clock
//     we    in   write enable
//     waddr in   write address (column)
//     wdata in   write data
//     raddr in   read address (column)
//     rdata out  registered read data
// -----------------------------------------------------------------------------
module sobel_line_buf #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 640,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// -----------------------------------------------------------------------------
// sobel_stream_engine
//   Streaming 3x3 Sobel edge detector for raster-order pixels. Builds its own
//   window from two line buffers and emits one saturated |Gx|+|Gy| per
//   interior pixel, in raster order of the window centres.
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     strm       --   sobel_stream_engine_if.slave (in_* / out_* streams)
//     thresh     in   binarisation threshold (only with SOBEL_THRESH_EN)
//     frame_err  out  sticky: in_sof accepted mid-frame; cleared by reset
//   Build option:
//     SOBEL_THRESH_EN  out_pix becomes all-ones/zero from sat_mag >= thresh,
//                      thresh sampled at each accepted in_sof.
// -----------------------------------------------------------------------------
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_stream_engine_if.slave strm,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0]    thresh,
`endif
  output logic                frame_err
);

  localparam int GW = grad_w(PIX_W);
  localparam int MW = mag_w(PIX_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [MW-1:0] PIX_MAX  = MW'((1 << PIX_W) - 1);

  localparam logic signed [GW-1:0] KS = GW'(K_SIDE);
  localparam logic signed [GW-1:0] KM = GW'(K_MID);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic en;
  logic acc;
  logic [LAT-1:0] vld_sr;
  logic [LAT-1:0] eof_sr;
  logic [PIX_W-1:0] out_pix_q;

  assign en            = strm.out_ready | ~vld_sr[LAT-1];
  assign acc           = strm.in_valid & en;
  assign strm.in_ready = en;
  assign strm.out_valid = vld_sr[LAT-1];
  assign strm.out_eof   = eof_sr[LAT-1];
  assign strm.out_pix   = out_pix_q;

  // ---------------------------------------------------------------------------
  // Position tracking
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col, pos_col, nxt_col, rd_col;
  logic [RW-1:0] row, pos_row, nxt_row;
  logic          interior;
  logic          is_last;

  always_comb begin
    pos_col = col;
    pos_row = row;
    if (strm.in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
    nxt_col = pos_col + CW'(1);
    nxt_row = pos_row;
    if (pos_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
    end
    // Line-buffer reads run one pixel ahead so their registered output is
    // ready on the accept that needs it. Only an in_sof pixel can be
    // mispredicted, and its line-buffer data feeds no output.
    rd_col   = acc ? nxt_col : col;
    interior = (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    is_last  = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else if (acc) begin
      col <= nxt_col;
      row <= nxt_row;
      if (strm.in_sof && ((col != '0) || (row != '0))) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= '0;
    end else if (acc && strm.in_sof) begin
      thr_q <= thresh;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds the previous line, lb1 the line before that.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] lb0_q;
  logic [PIX_W-1:0] lb1_q;

  sobel_line_buf #(.DW(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .we    (acc),
    .waddr (pos_col),
    .wdata (strm.in_pix),
    .raddr (rd_col),
    .rdata (lb0_q)
  );

  sobel_line_buf #(.DW(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .we    (acc),
    .waddr (pos_col),
    .wdata (lb0_q),
    .raddr (rd_col),
    .rdata (lb1_q)
  );

  // ---------------------------------------------------------------------------
  // S1: window shift (row 2 newest line, column 2 newest pixel)
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] w [3][3];

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int unsigned r = 0; r < 3; r++) begin
        w[r][0] <= w[r][1];
        w[r][1] <= w[r][2];
      end
      w[0][2] <= lb1_q;
      w[1][2] <= lb0_q;
      w[2][2] <= strm.in_pix;
    end
  end

  // The flag shift registers advance on en, not on acc, so an idle input
  // still drains results already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      eof_sr <= '0;
    end else if (en) begin
      vld_sr <= {vld_sr[LAT-2:0], acc & interior};
      eof_sr <= {eof_sr[LAT-2:0], acc & is_last};
    end
  end

  // ---------------------------------------------------------------------------
  // S2: gradients
  // ---------------------------------------------------------------------------
  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx_c, gy_c;
  logic signed [GW-1:0] gx_q, gy_q;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        p[r][c] = $signed(GW'(w[r][c]));
      end
    end
    gx_c = (KS * p[0][2] + KM * p[1][2] + KS * p[2][2])
         - (KS * p[0][0] + KM * p[1][0] + KS * p[2][0]);
    gy_c = (KS * p[2][0] + KM * p[2][1] + KS * p[2][2])
         - (KS * p[0][0] + KM * p[0][1] + KS * p[0][2]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      gx_q <= gx_c;
      gy_q <= gy_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: magnitude, saturation (and optional threshold)
  // ---------------------------------------------------------------------------
  logic [GW-1:0]    ax, ay;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] sat;
  logic [PIX_W-1:0] res;

  always_comb begin
    ax  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag = MW'(ax) + MW'(ay);
    sat = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
    res = (sat >= thr_q) ? '1 : '0;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pix_q <= '0;
    end else if (en) begin
      out_pix_q <= res;
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_sobel_stream_engine
//   Directed frame table with hand-computed Sobel outputs, plus sequences for
//   pipeline latency, back-pressure with input gaps, mid-frame in_sof and
//   mid-frame reset. Image rows are packed with column 0 in the top byte;
//   expected rows are packed with centre column 1 in the top byte.
// -----------------------------------------------------------------------------
module tb_sobel_stream_engine;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_err;
  bit   rdy_rand = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_stream_engine_if #(.PIX_W(PIX_W)) bus ();

`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thresh = '0;
`endif

  sobel_stream_engine #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strm      (bus),
`ifdef SOBEL_THRESH_EN
    .thresh    (thresh),
`endif
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             eof;
  } beat_t;

  typedef struct {
    string       name;
    logic [63:0] img [IMG_H];
    logic [47:0] exp [IMG_H-2];
  } vec_t;

  beat_t       got [$];
  vec_t        tbl [5];
  logic [63:0] img_a [IMG_H];
  logic [63:0] img_b [IMG_H];
  logic [7:0]  ex [NOUT];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Output monitor: records beats and checks hold-while-stalled.
  bit               stall_prev = 1'b0;
  logic [PIX_W-1:0] stall_pix;
  logic             stall_eof;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_pix", int'(bus.out_pix), int'(stall_pix));
        chk("hold_eof", int'(bus.out_eof), int'(stall_eof));
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back('{pix: bus.out_pix, eof: bus.out_eof});
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_pix  = bus.out_pix;
      stall_eof  = bus.out_eof;
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] getpix(input logic [63:0] img [IMG_H], input int r, input int c);
    return img[r][(IMG_W-1-c)*8 +: 8];
  endfunction

  // Independent reference: textbook Sobel on the whole image.
  function automatic logic [7:0] ref_pix(input logic [63:0] img [IMG_H], input int cr, input int cc);
    int v [3][3];
    int gx, gy, m;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[r][c] = int'(getpix(img, cr - 1 + r, cc - 1 + c));
    gx = (v[0][2] + 2*v[1][2] + v[2][2]) - (v[0][0] + 2*v[1][0] + v[2][0]);
    gy = (v[2][0] + 2*v[2][1] + v[2][2]) - (v[0][0] + 2*v[0][1] + v[0][2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 8'hFF : 8'(m);
  endfunction

  function automatic logic [7:0] post(input logic [7:0] m);
`ifdef SOBEL_THRESH_EN
    return (m >= thresh) ? 8'hFF : 8'h00;
`else
    return m;
`endif
  endfunction

  // Entered and left at posedge+1.
  task automatic send_pix(input logic [7:0] p, input logic sof, input bit gaps);
    int  n;
    bit  took;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    bus.in_sof   = sof;
    n = 0;
    do begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL accept_wait actual=%0d cycles required=<200", n);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] img [IMG_H], input bit gaps, input int npix);
    for (int i = 0; i < npix; i++)
      send_pix(getpix(img, i / IMG_W, i % IMG_W), i == 0, gaps);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (got.size() < NOUT && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic rows_to_exp(input logic [47:0] e [IMG_H-2], output logic [7:0] x [NOUT]);
    for (int i = 0; i < IMG_H - 2; i++)
      for (int j = 0; j < IMG_W - 2; j++)
        x[i*(IMG_W-2) + j] = e[i][(IMG_W-3-j)*8 +: 8];
  endtask

  task automatic model_exp(input logic [63:0] img [IMG_H], output logic [7:0] x [NOUT]);
    for (int cr = 1; cr < IMG_H - 1; cr++)
      for (int cc = 1; cc < IMG_W - 1; cc++)
        x[(cr-1)*(IMG_W-2) + cc - 1] = ref_pix(img, cr, cc);
  endtask

  task automatic check_frame(input string name, input logic [7:0] x [NOUT]);
    chk($sformatf("%s_count", name), got.size(), NOUT);
    for (int k = 0; k < NOUT; k++) begin
      if (k < got.size()) begin
        chk($sformatf("%s_pix%0d", name, k), int'(got[k].pix), int'(post(x[k])));
        chk($sformatf("%s_eof%0d", name, k), int'(got[k].eof), (k == NOUT - 1) ? 1 : 0);
      end
    end
    got.delete();
  endtask

  task automatic rand_img(output logic [63:0] img [IMG_H]);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][(IMG_W-1-c)*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pix    = '0;
    bus.out_ready = 1'b1;

    tbl[0].name = "flat";
    tbl[0].img  = '{default: 64'h4040404040404040};
    tbl[0].exp  = '{default: 48'h0};
    tbl[1].name = "vstep";
    tbl[1].img  = '{default: 64'h00000000FFFFFFFF};
    tbl[1].exp  = '{default: 48'h0000FFFF0000};
    tbl[2].name = "hot";
    tbl[2].img  = '{64'h0, 64'h0, 64'h0000100000000000, 64'h0, 64'h0, 64'h0};
    tbl[2].exp  = '{48'h202020000000, 48'h200020000000, 48'h202020000000, 48'h0};
    tbl[3].name = "hstep";
    tbl[3].img  = '{64'h0, 64'h0, 64'h0, 64'h1010101010101010,
                    64'h1010101010101010, 64'h1010101010101010};
    tbl[3].exp  = '{48'h0, 48'h404040404040, 48'h404040404040, 48'h0};
    tbl[4].name = "ramp";
    tbl[4].img  = '{default: 64'h0004080C1014181C};
    tbl[4].exp  = '{default: 48'h202020202020};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_pix", int'(bus.out_pix), 0);
    chk("rst_out_eof", int'(bus.out_eof), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: pixel 18 is (2,2), the first window-completing pixel.
    for (int i = 0; i < 19; i++) send_pix(8'h40, i == 0, 1'b0);
    @(negedge clk); chk("lat_cycle1", int'(bus.out_valid), 0);
    @(negedge clk); chk("lat_cycle2", int'(bus.out_valid), 0);
    @(negedge clk); chk("lat_cycle3", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    for (int i = 19; i < NPIX; i++) send_pix(8'h40, 1'b0, 1'b0);
    wait_drain();
    rows_to_exp(tbl[0].exp, ex);
    check_frame("lat_flat", ex);

    // Directed frame table
    for (int v = 0; v < 5; v++) begin
      send_frame(tbl[v].img, 1'b0, NPIX);
      wait_drain();
      rows_to_exp(tbl[v].exp, ex);
      check_frame(tbl[v].name, ex);
    end
    chk("no_err_after_table", int'(frame_err), 0);

    // Random pixels with back-pressure and input gaps
    rand_img(img_a);
    rdy_rand = 1'b1;
    send_frame(img_a, 1'b1, NPIX);
    wait_drain();
    rdy_rand = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    model_exp(img_a, ex);
    check_frame("rand_stall", ex);

    // in_sof reasserted at pixel 20
    rand_img(img_a);
    send_frame(img_a, 1'b0, 20);
    repeat (10) begin @(posedge clk); #1; end
    chk("sof_pre_err", int'(frame_err), 0);
    got.delete();
    rand_img(img_b);
    send_frame(img_b, 1'b0, NPIX);
    wait_drain();
    chk("sof_frame_err", int'(frame_err), 1);
    model_exp(img_b, ex);
    check_frame("sof_restart", ex);

    // Reset pulsed mid-frame with a stalled output
    rand_img(img_a);
    send_frame(img_a, 1'b0, 30);
    bus.out_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_eof", int'(bus.out_eof), 0);
    chk("mid_rst_pix", int'(bus.out_pix), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    got.delete();
    rand_img(img_b);
    send_frame(img_b, 1'b0, NPIX);
    wait_drain();
    model_exp(img_b, ex);
    check_frame("post_rst", ex);
    chk("post_rst_err", int'(frame_err), 0);

`ifdef SOBEL_THRESH_EN
    thresh = 8'h20;
    send_frame(tbl[2].img, 1'b0, NPIX);
    wait_drain();
    rows_to_exp(tbl[2].exp, ex);
    check_frame("thr20", ex);
    thresh = 8'h21;
    send_frame(tbl[2].img, 1'b0, NPIX);
    wait_drain();
    check_frame("thr21", ex);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
